// File: rtl/kbd_pkg.sv
// Scan-code constants, decoder states and the key-event record shared by the PS/2 keyboard path.
// The scan-code to ASCII table is compiled in only when KBD_ASCII_EN is defined.
package kbd_pkg;

   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   // Keyboard status/ack replies that never represent a key when seen unprefixed
   localparam int N_DISCARD = 6;
   localparam logic [N_DISCARD-1:0][7:0] DISCARD_CODES =
      {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK
   } dec_state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       rep;
      logic [7:0] ascii;
   } evt_t;

   function automatic logic is_discard(input logic [7:0] b);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < N_DISCARD; i++) begin
         if (b == DISCARD_CODES[i]) hit = 1'b1;
      end
      return hit;
   endfunction

`ifdef KBD_ASCII_EN
   function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic upper);
      logic [7:0] ch;
      ch = 8'h00;
      case (code)
         8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
         8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
         8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
         8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
         8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
         8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
         8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
         8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;  8'h25: ch = 8'h34;
         8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;  8'h3E: ch = 8'h38;
         8'h46: ch = 8'h39;  8'h45: ch = 8'h30;
         8'h29: ch = 8'h20;  8'h5A: ch = 8'h0D;  8'h66: ch = 8'h08;
         default: ch = 8'h00;
      endcase
      // Only letters live at 0x61 and above, so this folds case for letters alone
      if (upper && ch >= 8'h61) ch = ch - 8'h20;
      return ch;
   endfunction
`endif

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the pins, shifts 11-bit frames on ps2_clk falling edges,
// strobes a checked byte (or a frame_err pulse) one cycle after the stop-bit edge is detected.
module ps2_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_stb,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_prev;
   logic [9:0]             shreg;
   logic [3:0]             bit_cnt;
   logic [TW-1:0]          idle_cnt;
   logic                   fall;
   logic [10:0]            frame;

   assign fall  = clk_prev & ~clk_sync[SYNC_STAGES-1];
   // frame[0] is the start bit, frame[10] the stop bit arriving on this edge
   assign frame = {data_sync[SYNC_STAGES-1], shreg};

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
         shreg     <= '0;
         bit_cnt   <= '0;
         idle_cnt  <= '0;
         rx_byte   <= '0;
         byte_stb  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
         clk_prev  <= clk_sync[SYNC_STAGES-1];
         byte_stb  <= 1'b0;
         frame_err <= 1'b0;
         if (fall) begin
            idle_cnt <= '0;
            if (bit_cnt == 4'd10) begin
               bit_cnt <= '0;
               if (!frame[0] && frame[10] && (^frame[9:1])) begin
                  rx_byte  <= frame[8:1];
                  byte_stb <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end else begin
               shreg   <= {data_sync[SYNC_STAGES-1], shreg[9:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt != 4'd0) begin
            // A stalled partial frame is dropped silently so the next start bit realigns
            if (idle_cnt == TW'(TIMEOUT_CYC - 1)) begin
               bit_cnt  <= '0;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller: make/break/E0 decode, modifiers, repeats, event FIFO; evt_valid 3 cycles after stop edge.
// Holds head event stable under !evt_ready, drops and flags overflow when full; KBD_ASCII_EN adds ASCII translation.
module ps2_kbd_ctrl
   import kbd_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int CNT_W       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ps2_clk,
   input  logic             ps2_data,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [7:0]       evt_code,
   output logic             evt_ext,
   output logic             evt_break,
   output logic             evt_repeat,
   output logic [7:0]       evt_ascii,
   output logic             shift_state,
   output logic             caps_state,
   output logic [CNT_W-1:0] press_cnt,
   output logic             frame_err,
   output logic             overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [7:0] rx_byte;
   logic       byte_stb;

   ps2_rx #(
      .SYNC_STAGES(SYNC_STAGES),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_rx (
      .clk      (clk),
      .reset    (reset),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .rx_byte  (rx_byte),
      .byte_stb (byte_stb),
      .frame_err(frame_err)
   );

   dec_state_t state;
   logic       fire, fire_ext, fire_brk, make, rep, is_pfx;
   logic       is_lsh, is_rsh, is_caps;
   logic       shift_l, shift_r;
   logic       last_vld, last_ext;
   logic [7:0] last_code;
   logic [7:0] ascii;
   logic       emit;
   evt_t       emit_evt;

   assign is_pfx = (rx_byte == SC_EXT) || (rx_byte == SC_BRK);

   always_comb begin
      fire     = 1'b0;
      fire_ext = 1'b0;
      fire_brk = 1'b0;
      if (byte_stb && !is_pfx) begin
         case (state)
            ST_IDLE: fire = !is_discard(rx_byte);
            ST_EXT: begin
               fire     = 1'b1;
               fire_ext = 1'b1;
            end
            ST_BRK: begin
               fire     = 1'b1;
               fire_brk = 1'b1;
            end
            default: begin
               fire     = 1'b1;
               fire_ext = 1'b1;
               fire_brk = 1'b1;
            end
         endcase
      end
   end

   assign make    = fire && !fire_brk;
   assign rep     = make && last_vld && (last_ext == fire_ext) && (last_code == rx_byte);
   assign is_lsh  = !fire_ext && (rx_byte == SC_LSHIFT);
   assign is_rsh  = !fire_ext && (rx_byte == SC_RSHIFT);
   assign is_caps = !fire_ext && (rx_byte == SC_CAPS);
   assign shift_state = shift_l | shift_r;

   // Translation sees the modifier state as it stood before this event's own update
`ifdef KBD_ASCII_EN
   assign ascii = (make && !fire_ext) ? scan_to_ascii(rx_byte, shift_state ^ caps_state) : 8'h00;
`else
   assign ascii = 8'h00;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         emit       <= 1'b0;
         emit_evt   <= '0;
         shift_l    <= 1'b0;
         shift_r    <= 1'b0;
         caps_state <= 1'b0;
         press_cnt  <= '0;
         last_vld   <= 1'b0;
         last_ext   <= 1'b0;
         last_code  <= '0;
      end else begin
         emit <= fire;
         if (fire) begin
            emit_evt <= '{code: rx_byte, ext: fire_ext, brk: fire_brk, rep: rep, ascii: ascii};
         end
         if (byte_stb) begin
            case (state)
               ST_IDLE: begin
                  if (rx_byte == SC_EXT)      state <= ST_EXT;
                  else if (rx_byte == SC_BRK) state <= ST_BRK;
               end
               ST_EXT: begin
                  if (rx_byte == SC_BRK)      state <= ST_EXT_BRK;
                  else if (rx_byte != SC_EXT) state <= ST_IDLE;
               end
               default: begin
                  if (!is_pfx) state <= ST_IDLE;
               end
            endcase
         end
         if (make) begin
            if (!rep) begin
               press_cnt <= press_cnt + 1'b1;
               last_vld  <= 1'b1;
               last_ext  <= fire_ext;
               last_code <= rx_byte;
               if (is_caps) caps_state <= ~caps_state;
            end
            if (is_lsh) shift_l <= 1'b1;
            if (is_rsh) shift_r <= 1'b1;
         end
         if (fire && fire_brk) begin
            last_vld <= 1'b0;
            if (is_lsh) shift_l <= 1'b0;
            if (is_rsh) shift_r <= 1'b0;
         end
      end
   end

   evt_t          mem [FIFO_DEPTH];
   evt_t          head;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          full, pop, push_ok;

   assign evt_valid = (count != '0);
   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign pop       = evt_valid && evt_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts that push
   assign push_ok   = emit && (!full || pop);

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= emit_evt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (emit && full && !pop) overflow <= 1'b1;
         count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
      end
   end

   assign head       = evt_valid ? mem[rd_ptr] : '0;
   assign evt_code   = head.code;
   assign evt_ext    = head.ext;
   assign evt_break  = head.brk;
   assign evt_repeat = head.rep;
   assign evt_ascii  = head.ascii;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Bench for ps2_kbd_ctrl: byte-level keyboard model with cycle-timed event staging, directed and random frames.
`timescale 1ns/1ps
module tb_ps2_kbd_ctrl;
   localparam int DEPTH = 4;
   localparam int CW    = 4;
   localparam int SS    = 2;
   localparam int TO    = 300;
`ifdef KBD_ASCII_EN
   localparam bit AEN = 1'b1;
`else
   localparam bit AEN = 1'b0;
`endif

   logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1, evt_ready = 1'b0;
   logic evt_valid, evt_ext, evt_break, evt_repeat, shift_state, caps_state, frame_err, overflow;
   logic [7:0] evt_code, evt_ascii;
   logic [CW-1:0] press_cnt;

   ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .CNT_W(CW), .SYNC_STAGES(SS), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext),
      .evt_break(evt_break), .evt_repeat(evt_repeat), .evt_ascii(evt_ascii),
      .shift_state(shift_state), .caps_state(caps_state), .press_cnt(press_cnt),
      .frame_err(frame_err), .overflow(overflow));

   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [7:0] code; bit ext; bit brk; bit rep; logic [7:0] ascii; } ev_t;
   typedef struct { int due; logic [7:0] code; bit ext; bit brk; } stg_t;

   stg_t stage_q[$];
   int   err_q[$];
   ev_t  model_q[$];
   ev_t  log_q[$];
   ev_t  pend;
   bit   pend_vld = 0;
   bit   m_shl = 0, m_shr = 0, m_caps = 0, m_ovf = 0, l_vld = 0, l_ext = 0;
   logic [7:0] l_code = 0;
   int   m_cnt = 0, n_err_seen = 0;
   int   ready_mode = 1;
   bit   p_ext = 0, p_brk = 0;
   int   n_cmp = 0, n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

`ifdef KBD_ASCII_EN
   function automatic logic [7:0] model_ascii(input logic [7:0] code, input bit upper);
      logic [7:0] letters [26];
      logic [7:0] digits [10];
      letters = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                  8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
      digits  = '{8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46,8'h45};
      for (int i = 0; i < 26; i++)
         if (letters[i] == code) return 8'((upper ? 65 : 97) + i);
      for (int i = 0; i < 10; i++)
         if (digits[i] == code) return 8'((i == 9) ? 48 : 49 + i);
      if (code == 8'h29) return 8'h20;
      if (code == 8'h5A) return 8'h0D;
      if (code == 8'h66) return 8'h08;
      return 8'h00;
   endfunction
`endif

   // Compare process: model fields checked every cycle, then model advanced for the next edge
   initial begin : cmp
      ev_t  e, got;
      stg_t s;
      bit   pop;
      forever begin
         @(negedge clk);
         case (ready_mode)
            0: evt_ready = 1'($urandom_range(0, 1));
            1: evt_ready = 1'b1;
            default: evt_ready = 1'b0;
         endcase
         if (reset) begin
            stage_q.delete(); err_q.delete(); model_q.delete();
            pend_vld = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_ovf = 0;
            l_vld = 0; l_ext = 0; l_code = 0; m_cnt = 0;
         end else begin
            chk("evt_valid", evt_valid, model_q.size() != 0);
            if (model_q.size() != 0 && evt_valid) begin
               chk("evt_code", evt_code, model_q[0].code);
               chk("evt_ext", evt_ext, model_q[0].ext);
               chk("evt_break", evt_break, model_q[0].brk);
               chk("evt_repeat", evt_repeat, model_q[0].rep);
               chk("evt_ascii", evt_ascii, model_q[0].ascii);
            end
            chk("shift_state", shift_state, m_shl | m_shr);
            chk("caps_state", caps_state, m_caps);
            chk("press_cnt", press_cnt, m_cnt % (1 << CW));
            chk("overflow", overflow, m_ovf);
            chk("frame_err", frame_err, err_q.size() != 0 && err_q[0] == cyc);
            if (frame_err) n_err_seen++;
            if (err_q.size() != 0 && err_q[0] <= cyc) void'(err_q.pop_front());
            pop = (model_q.size() != 0) && evt_ready;
            if (pop) begin
               got.code = evt_code; got.ext = evt_ext; got.brk = evt_break;
               got.rep = evt_repeat; got.ascii = evt_ascii;
               log_q.push_back(got);
               void'(model_q.pop_front());
            end
            if (pend_vld) begin
               if (model_q.size() < DEPTH) model_q.push_back(pend);
               else m_ovf = 1;
               pend_vld = 0;
            end
            if (stage_q.size() != 0 && stage_q[0].due == cyc) begin
               s = stage_q.pop_front();
               e.code = s.code; e.ext = s.ext; e.brk = s.brk; e.ascii = 8'h00;
               e.rep = !s.brk && l_vld && (l_ext == s.ext) && (l_code == s.code);
`ifdef KBD_ASCII_EN
               if (!s.brk && !s.ext) e.ascii = model_ascii(s.code, (m_shl | m_shr) ^ m_caps);
`endif
               if (s.brk) begin
                  l_vld = 0;
                  if (!s.ext && s.code == 8'h12) m_shl = 0;
                  if (!s.ext && s.code == 8'h59) m_shr = 0;
               end else begin
                  if (!e.rep) begin
                     m_cnt++; l_vld = 1; l_ext = s.ext; l_code = s.code;
                     if (!s.ext && s.code == 8'h58) m_caps = ~m_caps;
                  end
                  if (!s.ext && s.code == 8'h12) m_shl = 1;
                  if (!s.ext && s.code == 8'h59) m_shr = 1;
               end
               pend = e; pend_vld = 1;
            end
         end
      end
   end

   // Byte-level decode of what the keyboard sent; events are staged for the cycle after the byte strobe
   task automatic decode_byte(input logic [7:0] b);
      stg_t st;
      if (b == 8'hE0) begin
         if (!p_brk) p_ext = 1;
      end else if (b == 8'hF0) begin
         p_brk = 1;
      end else if (!p_ext && !p_brk && (b == 8'h00 || b == 8'hAA || b == 8'hEE ||
                                        b == 8'hFA || b == 8'hFE || b == 8'hFF)) begin
      end else begin
         st.due = cyc + SS + 1; st.code = b; st.ext = p_ext; st.brk = p_brk;
         stage_q.push_back(st);
         p_ext = 0; p_brk = 0;
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         ps2_data = f[i];
         repeat (4) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10) begin
            if (bad_par) err_q.push_back(cyc + SS + 1);
            else decode_byte(b);
         end
         repeat (8) @(negedge clk);
         ps2_clk = 1'b1;
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic send(input logic [7:0] b);
      send_bits(b, 1'b0, 11);
   endtask

   task automatic settle();
      repeat (20) @(negedge clk);
   endtask

   task automatic chk_log(input string name, input int idx, input logic [7:0] code, input bit ext,
                          input bit brk, input bit rep, input logic [7:0] ascii);
      chk({name, "_present"}, log_q.size() > idx, 1);
      if (log_q.size() > idx) begin
         chk({name, "_code"}, log_q[idx].code, code);
         chk({name, "_ext"}, log_q[idx].ext, ext);
         chk({name, "_brk"}, log_q[idx].brk, brk);
         chk({name, "_rep"}, log_q[idx].rep, rep);
         chk({name, "_ascii"}, log_q[idx].ascii, ascii);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, evt_valid, 0);
      chk({tag, "_code"}, evt_code, 0);
      chk({tag, "_flags"}, {evt_ext, evt_break, evt_repeat}, 0);
      chk({tag, "_ascii"}, evt_ascii, 0);
      chk({tag, "_mods"}, {shift_state, caps_state}, 0);
      chk({tag, "_cnt"}, press_cnt, 0);
      chk({tag, "_err_ovf"}, {frame_err, overflow}, 0);
   endtask

   initial begin : wdog
      #900_000;
      $display("FAIL watchdog: simulation did not complete, limit 900000 ns");
      $fatal(1);
   end

   initial begin : stim
      int b, e0;
      logic [7:0] pool [12];
      logic [7:0] byt;
      pool = '{8'hE0, 8'hF0, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h1A, 8'h16, 8'h45, 8'h29, 8'hAA, 8'h75};

      repeat (5) @(negedge clk);
      chk_reset_outputs("reset");
      reset = 1'b0;
      ready_mode = 1;

      b = log_q.size();
      send(8'h1C);
      settle();
      chk("cnt_after_a", press_cnt, 1);
      send(8'hF0); send(8'h1C);
      settle();
      chk_log("a_make", b, 8'h1C, 0, 0, 0, AEN ? 8'h61 : 8'h00);
      chk_log("a_break", b + 1, 8'h1C, 0, 1, 0, 8'h00);

      b = log_q.size();
      send(8'h12);
      settle();
      chk("shift_held", shift_state, 1);
      send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
      settle();
      chk("shift_released", shift_state, 0);
      chk_log("shift_make", b, 8'h12, 0, 0, 0, 8'h00);
      chk_log("upper_a", b + 1, 8'h1C, 0, 0, 0, AEN ? 8'h41 : 8'h00);
      chk_log("shift_break", b + 3, 8'h12, 0, 1, 0, 8'h00);

      b = log_q.size();
      send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
      settle();
      chk_log("ext_make", b, 8'h75, 1, 0, 0, 8'h00);
      chk_log("ext_break", b + 1, 8'h75, 1, 1, 0, 8'h00);
      chk("cnt_after_ext", press_cnt, 4);

      b = log_q.size();
      send(8'h1C); send(8'h1C); send(8'h1C);
      settle();
      chk_log("rep0", b, 8'h1C, 0, 0, 0, AEN ? 8'h61 : 8'h00);
      chk_log("rep1", b + 1, 8'h1C, 0, 0, 1, AEN ? 8'h61 : 8'h00);
      chk_log("rep2", b + 2, 8'h1C, 0, 0, 1, AEN ? 8'h61 : 8'h00);
      chk("cnt_after_rep", press_cnt, 5);
      send(8'hF0); send(8'h1C);
      send(8'h58);
      settle();
      chk("caps_on", caps_state, 1);
      send(8'hF0); send(8'h58); send(8'h58);
      settle();
      chk("caps_off", caps_state, 0);
      chk("cnt_after_caps", press_cnt, 7);
      send(8'hF0); send(8'h58);

      b = log_q.size();
      e0 = n_err_seen;
      send_bits(8'h1C, 1'b1, 11);
      settle();
      chk("bad_parity_pulses", n_err_seen - e0, 1);
      chk("bad_parity_no_event", log_q.size() - b, 0);
      send_bits(8'h32, 1'b0, 3);
      repeat (TO + 50) @(negedge clk);
      send(8'h1C);
      settle();
      chk_log("after_timeout", b, 8'h1C, 0, 0, 0, AEN ? 8'h61 : 8'h00);
      chk("cnt_after_timeout", press_cnt, 8);
      send(8'hF0); send(8'h1C);
      settle();

      b = log_q.size();
      ready_mode = 2;
      send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
      settle();
      chk("overflow_set", overflow, 1);
      chk("full_valid", evt_valid, 1);
      chk("cnt_incl_dropped", press_cnt, 13);
      ready_mode = 1;
      settle();
      chk("fifo_kept", log_q.size() - b, DEPTH);
      chk_log("fifo0", b, 8'h15, 0, 0, 0, AEN ? 8'h71 : 8'h00);
      chk_log("fifo3", b + 3, 8'h2D, 0, 0, 0, AEN ? 8'h72 : 8'h00);

      ready_mode = 0;
      for (int i = 0; i < 140; i++) begin
         if ($urandom_range(0, 3) == 0) byt = 8'($urandom);
         else byt = pool[$urandom_range(0, 11)];
         send_bits(byt, $urandom_range(0, 19) == 0, 11);
      end
      ready_mode = 1;
      settle();

      ready_mode = 2;
      send(8'h1C);
      send_bits(8'h1B, 1'b0, 5);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      chk_reset_outputs("midframe_reset");
      reset = 1'b0;
      p_ext = 0; p_brk = 0;
      ready_mode = 1;
      b = log_q.size();
      send(8'h1C);
      settle();
      chk_log("post_reset", b, 8'h1C, 0, 0, 0, AEN ? 8'h61 : 8'h00);
      chk("post_reset_cnt", press_cnt, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Parametrised PS/2 keyboard controller: deserialises PS/2 frames, decodes make/break/extended sequences, tracks modifier state and typematic repeats, and queues key events in a FIFO behind a valid/ready interface. It is the next-generation replacement for the fixed single-key display path and sits between the board PS/2 pins and any consumer (seven-segment display logic, MMIO keyboard register, CPU-side driver).

## Interface
- FIFO_DEPTH, 8, event FIFO entries; power of two, ≥2
- CNT_W, 8, width of press counter
- SYNC_STAGES, 2, synchroniser flops on ps2_clk/ps2_data; ≥2
- TIMEOUT_CYC, 50000, clk cycles without a ps2_clk falling edge before a partial frame is abandoned

- clk  in  1  system clock; one clock domain
- reset  in  1  synchronous, active-high reset
- ps2_clk  in  1  PS/2 clock, asynchronous
- ps2_data  in  1  PS/2 data, asynchronous
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer accepts head event
- evt_code  out  8  scan code of head event
- evt_ext  out  1  head event had E0 prefix
- evt_break  out  1  head event is a release
- evt_repeat  out  1  head event is a typematic repeat make
- evt_ascii  out  8  ASCII of head event, 0 if none
- shift_state  out  1  either shift held
- caps_state  out  1  caps-lock toggle state
- press_cnt  out  CNT_W  non-repeat make events, wraps
- frame_err  out  1  one-cycle pulse on a bad frame
- overflow  out  1  sticky: event dropped on full FIFO

## Operation
- Receiver: synchronise both pins; falling edge = previous synced ps2_clk 1, current 0. Shift ps2_data on each edge: 11 bits, start(0), 8 data LSB first, odd parity, stop(1).
- Frame good (start 0, stop 1, odd parity over data+parity) → byte strobe; otherwise frame_err pulse, byte dropped.
- Mid-frame idle ≥ TIMEOUT_CYC cycles → bit counter cleared, no error pulse.
- Decoder FSM states IDLE, EXT, BRK, EXT_BRK. IDLE: E0→EXT, F0→BRK, 00/AA/EE/FA/FE/FF discarded, other → make(ext=0). EXT: F0→EXT_BRK, E0 stays, other → make(ext=1)→IDLE. BRK: E0/F0 stays, other → break(ext=0)→IDLE. EXT_BRK: E0/F0 stays, other → break(ext=1)→IDLE.
- Repeat: make whose {ext,code} equals last make with no intervening break → evt_repeat=1; not counted, no caps toggle.
- Modifiers: non-ext 12/59 make sets, break clears, its shift bit; shift_state = OR. Non-repeat non-ext 58 make toggles caps_state.
- press_cnt increments on every non-repeat make, including events dropped by a full FIFO; wraps 2^CNT_W−1 → 0.
- FIFO: push on emit; pop on evt_valid && evt_ready. Full and no pop → event dropped, overflow set until reset. Full with simultaneous pop → push accepted. Empty with push → no bypass; pop ignored.

## Timing
- Byte strobe one cycle after the stop-bit edge is detected; event emitted to FIFO next cycle; evt_valid high the cycle after (edge detect cycle T → evt_valid at T+3 from empty).
- Modifier/caps/press_cnt update in the emit cycle; ASCII is computed with the state before that update.
- Reset: all outputs 0, FSM IDLE, FIFO empty, partial frame discarded; synchroniser flops reset to 1 so no spurious edge after reset.
- evt_* outputs stable while evt_valid && !evt_ready.

## Configuration
- KBD_ASCII_EN defined: make events translated — letters 1C..1A map to 61..7A, or 41..5A when shift_state XOR caps_state; digit row 16,1E,26,25,2E,36,3D,3E,46,45 → 31..39,30; 29→20, 5A→0D, 66→08; ext, break and unmapped → 0.
- Undefined: evt_ascii tied 0, table absent; modifier tracking retained.

## Structure
- Package kbd_pkg: SC_EXT (E0), SC_BRK (F0), shift/caps codes, discard-code list, FSM state enum, event struct typedef {code, ext, brk, rep, ascii}.
- Sub-module ps2_rx: synchroniser, edge detect, frame shift/check, timeout; outputs byte, byte strobe, frame_err.

## Test plan
- Frame 1C, then F0 1C → make code=1C ascii=61 press_cnt=1; then break code=1C ascii=0.
- 12 make, 1C, F0 1C, F0 12 → A event ascii=41; shift_state 1 then 0.
- E0 75, E0 F0 75 → make ext=1 code=75 ascii=0, break ext=1.
- 1C ×3 without break → repeat flags 0,1,1; press_cnt=1; 58 twice with break between → caps_state 1 then 0.
- Bad parity frame → frame_err one pulse, no event; 3 bits then idle TIMEOUT_CYC → next good frame decodes.
- evt_ready=0, FIFO_DEPTH+1 makes → FIFO holds first FIFO_DEPTH, overflow=1; reset mid-frame → all outputs 0, FIFO empty.
